// File: rtl/operand_seq_ctrl.sv
// Operand-select sequencer: drives BUS_A/BUS_B mux selects, function select and write-back
// over one or two execute phases. Optional performance counters under OPSEQ_PERF_EN.
module operand_seq_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        INSTR_VALID,
    input  logic [31:0] INSTR,
    output logic        INSTR_READY,
    input  logic        STALL,
    input  logic        FU_READY,
    output logic        MA,
    output logic        MB,
    output logic        CS,
    output logic [3:0]  FS,
    output logic        FU_START,
    output logic        RW,
    output logic [4:0]  DA,
    output logic        BUSY,
    output logic        ERR
`ifdef OPSEQ_PERF_EN
    ,
    output logic [CNT_W-1:0] RETIRED,
    output logic [CNT_W-1:0] STALL_CYC
`endif
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be >= 1");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StWb} state_e;

    state_e        state_q, state_d;
    logic [6:0]    op_q, op_d;
    logic [4:0]    dr_q, dr_d;
    logic          phase2_q, phase2_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          ma_q, ma_d, mb_q, mb_d, cs_q, cs_d;
    logic [3:0]    fs_q, fs_d;
    logic [4:0]    da_q, da_d;
    logic          fu_start, rw;
    logic          link_p1;

    logic unused_instr;
    assign unused_instr = ^INSTR[19:0];

    assign link_p1 = (op_q[6:5] == 2'b11) && !phase2_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dr_d     = dr_q;
        phase2_d = phase2_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        cs_d     = cs_q;
        fs_d     = fs_q;
        da_d     = da_q;
        fu_start = 1'b0;
        rw       = 1'b0;
        case (state_q)
            StIdle: begin
                if (INSTR_VALID && !STALL) begin
                    op_d     = INSTR[31:25];
                    dr_d     = INSTR[24:20];
                    phase2_d = 1'b0;
                    cs_d     = INSTR[29];
                    fs_d     = INSTR[28:25];
                    da_d     = INSTR[24:20];
                    case (INSTR[31:30])
                        2'b00:   {ma_d, mb_d} = 2'b00;
                        2'b01:   {ma_d, mb_d} = 2'b01;
                        2'b10:   {ma_d, mb_d} = 2'b11;
                        default: begin
                            // LINK phase 1 saves the return address into r31
                            {ma_d, mb_d} = 2'b10;
                            da_d         = 5'd31;
                        end
                    endcase
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (!STALL) begin
                    fu_start = 1'b1;
                    tmo_d    = '0;
                    state_d  = StWait;
                end
            end
            StWait: begin
                // FU_READY takes priority over an expiring timeout
                if (FU_READY) begin
                    state_d = StWb;
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                rw = 1'b1;
                if (link_p1) begin
                    phase2_d = 1'b1;
                    ma_d     = 1'b0;
                    mb_d     = 1'b1;
                    fs_d     = 4'h0;
                    da_d     = dr_q;
                    state_d  = StIssue;
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= StIdle;
            op_q     <= '0;
            dr_q     <= '0;
            phase2_q <= 1'b0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            ma_q     <= 1'b0;
            mb_q     <= 1'b0;
            cs_q     <= 1'b0;
            fs_q     <= '0;
            da_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dr_q     <= dr_d;
            phase2_q <= phase2_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            cs_q     <= cs_d;
            fs_q     <= fs_d;
            da_q     <= da_d;
        end
    end

    assign INSTR_READY = (state_q == StIdle);
    assign BUSY        = (state_q != StIdle);
    assign MA          = ma_q;
    assign MB          = mb_q;
    assign CS          = cs_q;
    assign FS          = fs_q;
    assign DA          = da_q;
    assign FU_START    = fu_start;
    assign RW          = rw;
    assign ERR         = err_q;

`ifdef OPSEQ_PERF_EN
    logic [CNT_W-1:0] retired_q, stall_cyc_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            retired_q   <= '0;
            stall_cyc_q <= '0;
        end else begin
            if (state_q == StWb && !link_p1) begin
                retired_q <= retired_q + 1'b1;
            end
            if (STALL && state_q != StIdle) begin
                stall_cyc_q <= stall_cyc_q + 1'b1;
            end
        end
    end

    assign RETIRED   = retired_q;
    assign STALL_CYC = stall_cyc_q;
`endif

endmodule

// File: tb/tb_operand_seq_ctrl.sv
// Directed self-checking bench for operand_seq_ctrl; perf counters checked when OPSEQ_PERF_EN.
module tb_operand_seq_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        INSTR_VALID;
    logic [31:0] INSTR;
    logic        INSTR_READY;
    logic        STALL;
    logic        FU_READY;
    logic        MA, MB, CS;
    logic [3:0]  FS;
    logic        FU_START, RW;
    logic [4:0]  DA;
    logic        BUSY, ERR;
`ifdef OPSEQ_PERF_EN
    logic [15:0] RETIRED, STALL_CYC;
`endif

    operand_seq_ctrl #(.TIMEOUT_CYC(16), .CNT_W(16)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .INSTR_VALID (INSTR_VALID),
        .INSTR       (INSTR),
        .INSTR_READY (INSTR_READY),
        .STALL       (STALL),
        .FU_READY    (FU_READY),
        .MA          (MA),
        .MB          (MB),
        .CS          (CS),
        .FS          (FS),
        .FU_START    (FU_START),
        .RW          (RW),
        .DA          (DA),
        .BUSY        (BUSY),
        .ERR         (ERR)
`ifdef OPSEQ_PERF_EN
        ,
        .RETIRED     (RETIRED),
        .STALL_CYC   (STALL_CYC)
`endif
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int rw_cnt = 0;

    // Count write-back cycles mid-cycle, clear of both clock edges
    always @(posedge CLK) begin
        #2;
        if (RW === 1'b1) rw_cnt++;
    end

    typedef struct {
        logic [6:0] op;
        logic [4:0] dr;
        logic       ma;
        logic       mb;
        logic       cs;
        logic [3:0] fs;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_sel(input string nm, input logic ma, input logic mb, input logic cs,
                           input logic [3:0] fs, input logic [4:0] da);
        chk({nm, ".MA"}, MA, ma);
        chk({nm, ".MB"}, MB, mb);
        chk({nm, ".CS"}, CS, cs);
        chk({nm, ".FS"}, FS, fs);
        chk({nm, ".DA"}, DA, da);
    endtask

    task automatic issue_instr(input logic [6:0] op, input logic [4:0] dr);
        @(negedge CLK);
        chk("ready_before_accept", INSTR_READY, 1);
        INSTR       = {op, dr, 5'd1, 5'd2, 10'h0};
        INSTR_VALID = 1'b1;
        @(negedge CLK);
        INSTR_VALID = 1'b0;
        INSTR       = '0;
    endtask

    // Full single-phase run with FU_READY in the first WAIT cycle
    task automatic run_single(input string nm, input logic [6:0] op, input logic [4:0] dr,
                              input logic ma, input logic mb, input logic cs,
                              input logic [3:0] fs);
        int rw0;
        issue_instr(op, dr);
        rw0 = rw_cnt;
        chk_sel({nm, ".issue"}, ma, mb, cs, fs, dr);
        chk({nm, ".fu_start"}, FU_START, 1);
        chk({nm, ".ready_busy"}, INSTR_READY, 0);
        @(negedge CLK);
        chk({nm, ".wait_nostart"}, FU_START, 0);
        chk({nm, ".wait_norw"}, RW, 0);
        chk_sel({nm, ".wait"}, ma, mb, cs, fs, dr);
        FU_READY = 1'b1;
        @(negedge CLK);
        FU_READY = 1'b0;
        chk({nm, ".wb_rw"}, RW, 1);
        @(negedge CLK);
        chk({nm, ".idle_rw"}, RW, 0);
        chk({nm, ".idle_ready"}, INSTR_READY, 1);
        chk_sel({nm, ".hold"}, ma, mb, cs, fs, dr);
        chk({nm, ".rw_count"}, rw_cnt - rw0, 1);
    endtask

    initial begin
        int rw0;
        int waits;

        vecs[0] = '{op: 7'b0000011, dr: 5'd3,  ma: 1'b0, mb: 1'b0, cs: 1'b0, fs: 4'h3};
        vecs[1] = '{op: 7'b0110101, dr: 5'd9,  ma: 1'b0, mb: 1'b1, cs: 1'b1, fs: 4'h5};
        vecs[2] = '{op: 7'b1000010, dr: 5'd17, ma: 1'b1, mb: 1'b1, cs: 1'b0, fs: 4'h2};
        vecs[3] = '{op: 7'b0011111, dr: 5'd30, ma: 1'b0, mb: 1'b0, cs: 1'b1, fs: 4'hf};

        RESET = 1'b1; INSTR_VALID = 1'b0; INSTR = '0; STALL = 1'b0; FU_READY = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst.ready", INSTR_READY, 1);
        chk("rst.busy", BUSY, 0);
        chk("rst.err", ERR, 0);
        chk("rst.fu_start", FU_START, 0);
        chk("rst.rw", RW, 0);
        chk_sel("rst", 0, 0, 0, 4'h0, 5'd0);
        RESET = 1'b0;

        // FU_READY while idle must not start anything
        @(negedge CLK);
        FU_READY = 1'b1;
        @(negedge CLK);
        FU_READY = 1'b0;
        chk("idle_fu_ready.busy", BUSY, 0);
        chk("idle_fu_ready.rw", RW, 0);

        foreach (vecs[i])
            run_single($sformatf("vec%0d", i), vecs[i].op, vecs[i].dr, vecs[i].ma, vecs[i].mb,
                       vecs[i].cs, vecs[i].fs);
`ifdef OPSEQ_PERF_EN
        chk("perf.retired_table", RETIRED, 4);
`endif

        // LINK: two phases, two RW pulses three cycles apart
        issue_instr(7'b1100111, 5'd7);
        rw0 = rw_cnt;
        chk_sel("link.p1", 1, 0, 0, 4'h7, 5'd31);
        chk("link.p1.start", FU_START, 1);
        @(negedge CLK);
        chk("link.p1.wait_ready", INSTR_READY, 0);
        FU_READY = 1'b1;
        @(negedge CLK);
        FU_READY = 1'b0;
        chk("link.p1.rw", RW, 1);
        chk("link.p1.wb_ready", INSTR_READY, 0);
        @(negedge CLK);
        chk_sel("link.p2", 0, 1, 0, 4'h0, 5'd7);
        chk("link.p2.start", FU_START, 1);
        chk("link.p2.norw", RW, 0);
        chk("link.p2.ready", INSTR_READY, 0);
        @(negedge CLK);
        chk("link.p2.wait_ready", INSTR_READY, 0);
        FU_READY = 1'b1;
        @(negedge CLK);
        FU_READY = 1'b0;
        chk("link.p2.rw", RW, 1);
        @(negedge CLK);
        chk("link.done_ready", INSTR_READY, 1);
        chk("link.rw_count", rw_cnt - rw0, 2);

        // STALL held for three ISSUE cycles delays FU_START by three cycles
        issue_instr(7'b0000011, 5'd5);
        STALL = 1'b1;
        #1;
        chk("stall.c1.start", FU_START, 0);
        for (int k = 2; k <= 3; k++) begin
            @(negedge CLK);
            chk($sformatf("stall.c%0d.start", k), FU_START, 0);
            chk($sformatf("stall.c%0d.busy", k), BUSY, 1);
            chk_sel($sformatf("stall.c%0d", k), 0, 0, 0, 4'h3, 5'd5);
        end
        @(negedge CLK);
        STALL = 1'b0;
        #1;
        chk("stall.release_start", FU_START, 1);
        @(negedge CLK);
        FU_READY = 1'b1;
        @(negedge CLK);
        FU_READY = 1'b0;
        chk("stall.rw", RW, 1);
        @(negedge CLK);
`ifdef OPSEQ_PERF_EN
        chk("perf.stall_cyc", STALL_CYC, 3);
        chk("perf.retired", RETIRED, 6);
`endif

        // FU_READY in the last allowed WAIT cycle beats the timeout
        issue_instr(7'b0000001, 5'd2);
        rw0 = rw_cnt;
        @(negedge CLK);
        repeat (15) @(negedge CLK);
        chk("edge.still_wait", BUSY, 1);
        FU_READY = 1'b1;
        @(negedge CLK);
        FU_READY = 1'b0;
        chk("edge.rw", RW, 1);
        chk("edge.err", ERR, 0);
        @(negedge CLK);
        chk("edge.rw_count", rw_cnt - rw0, 1);

        // Timeout: no FU_READY at all
        issue_instr(7'b0000001, 5'd2);
        rw0 = rw_cnt;
        @(negedge CLK);
        waits = 0;
        while (BUSY && waits < 40) begin
            waits++;
            @(negedge CLK);
        end
        chk("tmo.wait_cycles", waits, 16);
        chk("tmo.err", ERR, 1);
        chk("tmo.ready", INSTR_READY, 1);
        chk("tmo.no_rw", rw_cnt - rw0, 0);

        run_single("after_tmo", 7'b0110101, 5'd4, 0, 1, 1, 4'h5);
        chk("tmo.err_sticky", ERR, 1);

        // Asynchronous reset in WAIT of LINK phase 1
        issue_instr(7'b1100111, 5'd7);
        rw0 = rw_cnt;
        @(negedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        chk("rst_mid.busy", BUSY, 0);
        chk("rst_mid.ready", INSTR_READY, 1);
        chk("rst_mid.err", ERR, 0);
        chk_sel("rst_mid", 0, 0, 0, 4'h0, 5'd0);
        @(negedge CLK);
        RESET = 1'b0;
        chk("rst_mid.no_rw", rw_cnt - rw0, 0);
        run_single("after_rst", 7'b1000010, 5'd12, 1, 1, 0, 4'h2);
        chk("after_rst.err", ERR, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
